// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU datapath: width and ALU opcodes.
package cpu_pkg;
  localparam int DATA_W = 16;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_MUL   = 4'b0100;
  localparam logic [3:0] ALU_DIV   = 4'b0101;
  localparam logic [3:0] ALU_SLL   = 4'b0110;
  localparam logic [3:0] ALU_SRL   = 4'b0111;
  localparam logic [3:0] ALU_ROL   = 4'b1000;
  localparam logic [3:0] ALU_ROR   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;
endpackage

// File: rtl/exec_mem_unit_dmem_array.sv
// Word-organised data memory: synchronous write/clear, combinational read.
module dmem_array
  import cpu_pkg::*;
#(
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [MEM_AW-1:0] index,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = 2 ** MEM_AW;

  logic [DATA_W-1:0] mem [DEPTH];

  // Reset clears every word and blocks the write of that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[index] <= wdata;
    end
  end

  // No write bypass: the new word appears only after the edge.
  assign rdata = mem[index];
endmodule

// File: rtl/exec_mem_unit.sv
// Datapath slice: PC+2 incrementer, dual-result ALU and data memory.
module exec_mem_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W_P = 16,
  parameter int MEM_AW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       pc_in,
  output logic [15:0]       pc_plus2,
  input  logic [15:0]       alu_a,
  input  logic [15:0]       alu_b,
  input  logic [3:0]        alu_op,
  output logic [15:0]       alu_res,
  output logic [15:0]       alu_res_hi,
  output logic              alu_ovf,
  input  logic              mem_we,
  input  logic [15:0]       mem_addr,
  input  logic [15:0]       mem_wdata,
  output logic [15:0]       mem_rdata
);
  // Only a 16-bit datapath exists; DATA_W_P documents that at the boundary.
  logic unused_param;
  assign unused_param = (DATA_W_P == DATA_W);

  // Fetch-stage incrementer, wraps modulo 2^16.
  assign pc_plus2 = pc_in + 16'd2;

  logic [15:0] sum, diff;
  logic [31:0] prod, rot_l, rot_r;
  logic [15:0] quot, rem;
  logic [3:0]  sh;

  assign sum   = alu_a + alu_b;
  assign diff  = alu_a - alu_b;
  assign prod  = $signed({{16{alu_a[15]}}, alu_a}) * $signed({{16{alu_b[15]}}, alu_b});
  assign sh    = alu_b[3:0];
  assign rot_l = {alu_a, alu_a} << sh;
  assign rot_r = {alu_a, alu_a} >> sh;

  // Divide only on legal operands so the two error cases never reach the divider.
  always_comb begin
    quot = '0;
    rem  = '0;
    if (alu_b != 16'h0000 && !(alu_a == 16'h8000 && alu_b == 16'hFFFF)) begin
      quot = $signed(alu_a) / $signed(alu_b);
      rem  = $signed(alu_a) % $signed(alu_b);
    end
  end

  // Result/flag select; res_hi and ovf stay 0 unless an op drives them.
  always_comb begin
    alu_res    = '0;
    alu_res_hi = '0;
    alu_ovf    = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = (alu_a[15] == alu_b[15]) && (sum[15] != alu_a[15]);
      end
      ALU_SUB: begin
        alu_res = diff;
        alu_ovf = (alu_a[15] != alu_b[15]) && (diff[15] != alu_a[15]);
      end
      ALU_AND: alu_res = alu_a & alu_b;
      ALU_OR:  alu_res = alu_a | alu_b;
      ALU_MUL: begin
        alu_res    = prod[15:0];
        alu_res_hi = prod[31:16];
      end
      ALU_DIV: begin
        if (alu_b == 16'h0000) begin
          alu_res_hi = alu_a;
          alu_ovf    = 1'b1;
        end else if (alu_a == 16'h8000 && alu_b == 16'hFFFF) begin
          alu_res = 16'h8000;
          alu_ovf = 1'b1;
        end else begin
          alu_res    = quot;
          alu_res_hi = rem;
        end
      end
      ALU_SLL:   alu_res = alu_a << sh;
      ALU_SRL:   alu_res = alu_a >> sh;
      ALU_ROL:   alu_res = rot_l[31:16];
      ALU_ROR:   alu_res = rot_r[15:0];
      ALU_PASSB: alu_res = alu_b;
      default:   ;
    endcase
  end

  // Word index drops the byte bit and the high bits, so addresses wrap.
  logic unused_addr;
  assign unused_addr = ^{mem_addr[15:MEM_AW+1], mem_addr[0]};

  dmem_array #(.MEM_AW(MEM_AW)) u_dmem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .index (mem_addr[MEM_AW:1]),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );
endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed self-checking bench for exec_mem_unit.
module tb_exec_mem_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_in, pc_plus2;
  logic [15:0] alu_a, alu_b, alu_res, alu_res_hi;
  logic [3:0]  alu_op;
  logic        alu_ovf;
  logic        mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  exec_mem_unit dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .pc_plus2   (pc_plus2),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_res    (alu_res),
    .alu_res_hi (alu_res_hi),
    .alu_ovf    (alu_ovf),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    alu_op = op; alu_a = a; alu_b = b;
    #1;
  endtask

  // One clock edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_we = 1'b1; mem_addr = 16'h0010; mem_wdata = 16'hDEAD;
    pc_in = 16'h0000; alu_op = 4'h0; alu_a = '0; alu_b = '0;
    tick();
    tick();

    // Reset with we=1 must not write; everything reads 0.
    chk("rst_rd_0010", mem_rdata, 16'h0000);
    mem_addr = 16'h0000; #1;
    chk("rst_rd_0000", mem_rdata, 16'h0000);
    mem_addr = 16'h01FE; #1;
    chk("rst_rd_01FE", mem_rdata, 16'h0000);
    rst = 1'b0; mem_we = 1'b0;

    // Incrementer
    pc_in = 16'h0000; #1; chk("pc_0000", pc_plus2, 16'h0002);
    pc_in = 16'hFFFE; #1; chk("pc_FFFE", pc_plus2, 16'h0000);
    pc_in = 16'h1234; #1; chk("pc_1234", pc_plus2, 16'h1236);

    // ADD / SUB
    alu(4'h0, 16'h7FFF, 16'h0001);
    chk("add_res", alu_res, 16'h8000); chk("add_ovf", {15'b0, alu_ovf}, 16'h1);
    alu(4'h0, 16'h0003, 16'h0004);
    chk("add2_res", alu_res, 16'h0007); chk("add2_ovf", {15'b0, alu_ovf}, 16'h0);
    alu(4'h1, 16'h0005, 16'h0007);
    chk("sub_res", alu_res, 16'hFFFE); chk("sub_ovf", {15'b0, alu_ovf}, 16'h0);
    alu(4'h1, 16'h8000, 16'h0001);
    chk("sub2_res", alu_res, 16'h7FFF); chk("sub2_ovf", {15'b0, alu_ovf}, 16'h1);

    // AND / OR / PASSB / unused opcode
    alu(4'h2, 16'hF0F0, 16'hFF00); chk("and", alu_res, 16'hF000);
    alu(4'h3, 16'hF0F0, 16'h0F00); chk("or", alu_res, 16'hFFF0);
    alu(4'hA, 16'h1111, 16'hBEEF); chk("passb", alu_res, 16'hBEEF);
    chk("passb_hi", alu_res_hi, 16'h0000);
    alu(4'hF, 16'h1111, 16'h2222); chk("undef_res", alu_res, 16'h0000);

    // MUL
    alu(4'h4, 16'h0100, 16'h0200);
    chk("mul_res", alu_res, 16'h0000); chk("mul_hi", alu_res_hi, 16'h0002);
    alu(4'h4, 16'hFFFF, 16'h0003);
    chk("mul_neg_res", alu_res, 16'hFFFD); chk("mul_neg_hi", alu_res_hi, 16'hFFFF);

    // DIV
    alu(4'h5, 16'hFFFA, 16'h0004);
    chk("div_res", alu_res, 16'hFFFF); chk("div_hi", alu_res_hi, 16'hFFFE);
    chk("div_ovf", {15'b0, alu_ovf}, 16'h0);
    alu(4'h5, 16'h1234, 16'h0000);
    chk("div0_res", alu_res, 16'h0000); chk("div0_hi", alu_res_hi, 16'h1234);
    chk("div0_ovf", {15'b0, alu_ovf}, 16'h1);
    alu(4'h5, 16'h8000, 16'hFFFF);
    chk("divmin_res", alu_res, 16'h8000); chk("divmin_hi", alu_res_hi, 16'h0000);
    chk("divmin_ovf", {15'b0, alu_ovf}, 16'h1);

    // Shifts / rotates, a=8001h b=1 then a larger amount using b[3:0] only
    alu(4'h6, 16'h8001, 16'h0001); chk("sll", alu_res, 16'h0002);
    alu(4'h7, 16'h8001, 16'h0001); chk("srl", alu_res, 16'h4000);
    alu(4'h8, 16'h8001, 16'h0001); chk("rol", alu_res, 16'h0003);
    alu(4'h9, 16'h8001, 16'h0001); chk("ror", alu_res, 16'hC000);
    alu(4'h8, 16'h1234, 16'h0014); chk("rol4", alu_res, 16'h2341);
    alu(4'h9, 16'h1234, 16'h0014); chk("ror4", alu_res, 16'h4123);

    // Memory write, no bypass before the edge
    @(negedge clk);
    mem_we = 1'b1; mem_addr = 16'h0010; mem_wdata = 16'h1234; #1;
    chk("wr_pre_edge", mem_rdata, 16'h0000);
    tick();
    mem_we = 1'b0;
    chk("wr_0010", mem_rdata, 16'h1234);
    mem_addr = 16'h0011; #1; chk("wr_0011", mem_rdata, 16'h1234);

    // we=0 leaves the word alone
    mem_wdata = 16'h5555; tick();
    chk("we0_keep", mem_rdata, 16'h1234);

    // Wrap: 0200h aliases 0000h
    @(negedge clk);
    mem_we = 1'b1; mem_addr = 16'h0200; mem_wdata = 16'hABCD;
    tick();
    mem_we = 1'b0; mem_addr = 16'h0000; #1;
    chk("wrap_0000", mem_rdata, 16'hABCD);
    mem_addr = 16'h0010; #1; chk("wrap_0010", mem_rdata, 16'h1234);

    // Reset mid-sequence with a pending write clears all and drops the write
    @(negedge clk);
    rst = 1'b1; mem_we = 1'b1; mem_addr = 16'h0020; mem_wdata = 16'h7777;
    tick();
    rst = 1'b0; mem_we = 1'b0; #1;
    chk("rst2_0020", mem_rdata, 16'h0000);
    mem_addr = 16'h0010; #1; chk("rst2_0010", mem_rdata, 16'h0000);
    mem_addr = 16'h0000; #1; chk("rst2_0000", mem_rdata, 16'h0000);

    // ALU is unaffected by reset
    rst = 1'b1;
    alu(4'h0, 16'h0001, 16'h0002); chk("alu_in_rst", alu_res, 16'h0003);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
